// File: rtl/apb_pkg.sv
// apb_pkg: shared types and default sizing for the APB manager slice.
package apb_pkg;

    // Transfer sequencing states of the manager
    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_e;

    // APB PPROT-style protection attributes
    typedef logic [3:0] apb_prot_t;

    localparam int unsigned APB_ADDR_WIDTH     = 32;
    localparam int unsigned APB_DATA_WIDTH     = 32;
    localparam int unsigned APB_PRPH_NUM       = 4;
    localparam int unsigned APB_REGION_BITS    = 12;
    localparam int unsigned APB_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/apb_decoder.sv
// apb_decoder: maps a byte address onto one of PrphNum equally sized regions.
// Region index is addr >> RegionBits; indices at or beyond PrphNum miss.
module apb_decoder
    import apb_pkg::*;
#(
    parameter int unsigned AddrWidth  = APB_ADDR_WIDTH,
    parameter int unsigned PrphNum    = APB_PRPH_NUM,
    parameter int unsigned RegionBits = APB_REGION_BITS
) (
    input  logic [AddrWidth-1:0] addr,
    output logic [PrphNum-1:0]   sel,
    output logic                 hit
);

    logic [AddrWidth-1:0] index;

    // Region index, hit flag and one-hot lane select
    always_comb begin
        index = addr >> RegionBits;
        hit   = (index < AddrWidth'(PrphNum));
        sel   = '0;
        for (int unsigned i = 0; i < PrphNum; i++) begin
            sel[i] = (index == AddrWidth'(i));
        end
    end

endmodule

// File: rtl/apb_manager.sv
// apb_manager: single-outstanding command-to-APB bridge.
// Optional feature: define APB_TIMEOUT_EN to bound the ACCESS phase to
// TimeoutCycles cycles; on expiry the transfer completes with an error.
module apb_manager
    import apb_pkg::*;
#(
    parameter int unsigned AddrWidth     = APB_ADDR_WIDTH,
    parameter int unsigned DataWidth     = APB_DATA_WIDTH,
    parameter int unsigned PrphNum       = APB_PRPH_NUM,
    parameter int unsigned RegionBits    = APB_REGION_BITS,
    parameter int unsigned TimeoutCycles = APB_TIMEOUT_CYCLES
) (
    input  logic                   clk,
    input  logic                   nReset,
    input  logic                   reqValid,
    output logic                   reqReady,
    input  logic [AddrWidth-1:0]   reqAddr,
    input  logic                   reqWrite,
    input  logic [DataWidth-1:0]   reqWData,
    input  logic [DataWidth/8-1:0] reqStrb,
    input  logic [3:0]             reqProt,
    output logic                   rspValid,
    input  logic                   rspReady,
    output logic [DataWidth-1:0]   rspRData,
    output logic                   rspError,
    output logic [AddrWidth-1:0]   apbAddr,
    output logic [3:0]             apbProt,
    output logic [PrphNum-1:0]     apbSel,
    output logic                   apbEnable,
    output logic                   apbWrite,
    output logic [DataWidth-1:0]   apbWData,
    output logic [DataWidth/8-1:0] apbStrb,
    input  logic                   apbReady,
    input  logic [DataWidth-1:0]   apbRData,
    input  logic                   apbSlvError
);

    localparam int unsigned StrbWidth = DataWidth / 8;

    // Elaboration-time parameter sanity checks
    if (DataWidth % 8 != 0) begin : g_bad_data_width
        $error("apb_manager: DataWidth must be a multiple of 8");
    end
    if (TimeoutCycles == 0) begin : g_bad_timeout
        $error("apb_manager: TimeoutCycles must be at least 1");
    end

    apb_state_e             state_q, state_d;
    logic [PrphNum-1:0]     dec_sel;
    logic                   dec_hit;
    logic                   capture;

    logic [AddrWidth-1:0]   addr_q;
    apb_prot_t              prot_q;
    logic                   write_q;
    logic [DataWidth-1:0]   wdata_q;
    logic [StrbWidth-1:0]   strb_q;
    logic [PrphNum-1:0]     sel_q;

    logic                   rsp_load;
    logic [DataWidth-1:0]   rsp_rdata_d, rdata_q;
    logic                   rsp_error_d, error_q;
    logic                   tmo_hit;

    apb_decoder #(
        .AddrWidth  (AddrWidth),
        .PrphNum    (PrphNum),
        .RegionBits (RegionBits)
    ) u_decoder (
        .addr (reqAddr),
        .sel  (dec_sel),
        .hit  (dec_hit)
    );

    assign reqReady = nReset && (state_q == IDLE);
    assign capture  = reqValid && reqReady;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);
    logic [CntWidth-1:0] tmo_cnt_q;

    // ACCESS-cycle counter, cleared whenever a new transfer enters SETUP
    always_ff @(posedge clk) begin
        if (!nReset) begin
            tmo_cnt_q <= '0;
        end else if (capture && dec_hit) begin
            tmo_cnt_q <= '0;
        end else if (state_q == ACCESS) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    // Current ACCESS cycle is the TimeoutCycles-th one
    assign tmo_hit = (tmo_cnt_q == CntWidth'(TimeoutCycles - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!nReset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and response-capture decisions
    always_comb begin
        state_d     = state_q;
        rsp_load    = 1'b0;
        rsp_rdata_d = '0;
        rsp_error_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (reqValid) begin
                    if (dec_hit) begin
                        state_d = SETUP;
                    end else begin
                        state_d     = RESP;
                        rsp_load    = 1'b1;
                        rsp_error_d = 1'b1;
                    end
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // A ready peripheral wins over a simultaneous timeout
                if (apbReady) begin
                    state_d     = RESP;
                    rsp_load    = 1'b1;
                    rsp_rdata_d = write_q ? '0 : apbRData;
                    rsp_error_d = apbSlvError;
                end else if (tmo_hit) begin
                    state_d     = RESP;
                    rsp_load    = 1'b1;
                    rsp_error_d = 1'b1;
                end
            end
            RESP: begin
                if (rspReady) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // APB request fields, latched only for decoded hits and held otherwise
    always_ff @(posedge clk) begin
        if (!nReset) begin
            addr_q  <= '0;
            prot_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            sel_q   <= '0;
        end else if (capture && dec_hit) begin
            addr_q  <= reqAddr;
            prot_q  <= reqProt;
            write_q <= reqWrite;
            wdata_q <= reqWData;
            strb_q  <= reqWrite ? reqStrb : '0;
            sel_q   <= dec_sel;
        end
    end

    // Response registers, held through RESP until accepted
    always_ff @(posedge clk) begin
        if (!nReset) begin
            rdata_q <= '0;
            error_q <= 1'b0;
        end else if (rsp_load) begin
            rdata_q <= rsp_rdata_d;
            error_q <= rsp_error_d;
        end
    end

    assign apbSel    = ((state_q == SETUP) || (state_q == ACCESS)) ? sel_q : '0;
    assign apbEnable = (state_q == ACCESS);
    assign apbAddr   = addr_q;
    assign apbProt   = prot_q;
    assign apbWrite  = write_q;
    assign apbWData  = wdata_q;
    assign apbStrb   = strb_q;
    assign rspValid  = (state_q == RESP);
    assign rspRData  = rdata_q;
    assign rspError  = error_q;

endmodule

// File: tb/tb_apb_manager.sv
// tb_apb_manager: directed vector bench for apb_manager (default parameters).
// Honours APB_TIMEOUT_EN to select the ACCESS-timeout expectations.
module tb_apb_manager;

    logic        clk = 1'b0;
    logic        nReset;
    logic        reqValid;
    logic        reqReady;
    logic [31:0] reqAddr;
    logic        reqWrite;
    logic [31:0] reqWData;
    logic [3:0]  reqStrb;
    logic [3:0]  reqProt;
    logic        rspValid;
    logic        rspReady;
    logic [31:0] rspRData;
    logic        rspError;
    logic [31:0] apbAddr;
    logic [3:0]  apbProt;
    logic [3:0]  apbSel;
    logic        apbEnable;
    logic        apbWrite;
    logic [31:0] apbWData;
    logic [3:0]  apbStrb;
    logic        apbReady;
    logic [31:0] apbRData;
    logic        apbSlvError;

    int checks = 0;
    int errors = 0;

    apb_manager #(
        .AddrWidth     (32),
        .DataWidth     (32),
        .PrphNum       (4),
        .RegionBits    (12),
        .TimeoutCycles (16)
    ) dut (
        .clk         (clk),
        .nReset      (nReset),
        .reqValid    (reqValid),
        .reqReady    (reqReady),
        .reqAddr     (reqAddr),
        .reqWrite    (reqWrite),
        .reqWData    (reqWData),
        .reqStrb     (reqStrb),
        .reqProt     (reqProt),
        .rspValid    (rspValid),
        .rspReady    (rspReady),
        .rspRData    (rspRData),
        .rspError    (rspError),
        .apbAddr     (apbAddr),
        .apbProt     (apbProt),
        .apbSel      (apbSel),
        .apbEnable   (apbEnable),
        .apbWrite    (apbWrite),
        .apbWData    (apbWData),
        .apbStrb     (apbStrb),
        .apbReady    (apbReady),
        .apbRData    (apbRData),
        .apbSlvError (apbSlvError)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [3:0]  prot;
        int          waits;
        logic [31:0] rdata;
        logic        slverr;
        logic        hit;
        logic [3:0]  sel;
        logic        err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One complete command with rspReady held high; checks every cycle
    task automatic run_vec(input vec_t v);
        logic [3:0] exp_strb;
        exp_strb = v.write ? v.strb : 4'h0;
        @(posedge clk); #1;
        reqValid = 1'b1; reqAddr = v.addr; reqWrite = v.write;
        reqWData = v.wdata; reqStrb = v.strb; reqProt = v.prot;
        rspReady = 1'b1; apbReady = 1'b0;
        @(negedge clk);
        chk({v.name, "_idle_ready"}, reqReady, 1'b1);
        @(posedge clk); #1;
        reqValid = 1'b0; reqAddr = 32'hFFFF_FFFF; reqWData = 32'h0; reqStrb = 4'h0;
        if (v.hit) begin
            @(negedge clk);
            chk({v.name, "_setup_sel"}, apbSel, v.sel);
            chk({v.name, "_setup_en"}, apbEnable, 1'b0);
            chk({v.name, "_setup_addr"}, apbAddr, v.addr);
            chk({v.name, "_setup_write"}, apbWrite, v.write);
            chk({v.name, "_setup_wdata"}, apbWData, v.wdata);
            chk({v.name, "_setup_strb"}, apbStrb, exp_strb);
            chk({v.name, "_setup_prot"}, apbProt, v.prot);
            chk({v.name, "_setup_reqready"}, reqReady, 1'b0);
            chk({v.name, "_setup_rspvalid"}, rspValid, 1'b0);
            for (int c = 0; c <= v.waits; c++) begin
                @(posedge clk); #1;
                apbReady    = (c == v.waits);
                apbRData    = (c == v.waits) ? v.rdata : 32'hBAD0_0000 + 32'(c);
                apbSlvError = (c == v.waits) ? v.slverr : 1'b1;
                @(negedge clk);
                chk({v.name, "_access_en"}, apbEnable, 1'b1);
                chk({v.name, "_access_sel"}, apbSel, v.sel);
                chk({v.name, "_access_addr"}, apbAddr, v.addr);
                chk({v.name, "_access_strb"}, apbStrb, exp_strb);
                chk({v.name, "_access_rspvalid"}, rspValid, 1'b0);
            end
            @(posedge clk); #1;
            apbReady = 1'b0; apbRData = 32'h0; apbSlvError = 1'b0;
        end
        @(negedge clk);
        chk({v.name, "_rsp_valid"}, rspValid, 1'b1);
        chk({v.name, "_rsp_error"}, rspError, v.err);
        chk({v.name, "_rsp_rdata"}, rspRData, v.exp_rdata);
        chk({v.name, "_rsp_sel"}, apbSel, 4'h0);
        chk({v.name, "_rsp_en"}, apbEnable, 1'b0);
        chk({v.name, "_rsp_reqready"}, reqReady, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        //       name       addr          wr    wdata          strb  prot  waits rdata          serr  hit   sel     err   exp_rdata
        vecs[0] = '{"wr0w",   32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 4'hF, 4'h0, 0, 32'hCAFE_F00D, 1'b0, 1'b1, 4'b0010, 1'b0, 32'h0};
        vecs[1] = '{"rd3w",   32'h0000_3000, 1'b0, 32'h1111_2222, 4'hF, 4'h2, 3, 32'h1234_5678, 1'b0, 1'b1, 4'b1000, 1'b0, 32'h1234_5678};
        vecs[2] = '{"miss4",  32'h0000_4000, 1'b1, 32'h0BAD_CAFE, 4'hF, 4'h0, 0, 32'h0,         1'b0, 1'b0, 4'b0000, 1'b1, 32'h0};
        vecs[3] = '{"rderr",  32'h0000_0010, 1'b0, 32'h0,         4'h0, 4'h1, 1, 32'hA5A5_A5A5, 1'b1, 1'b1, 4'b0001, 1'b1, 32'hA5A5_A5A5};
        vecs[4] = '{"wr2w",   32'h0000_2FFC, 1'b1, 32'h0102_0304, 4'h3, 4'h5, 2, 32'h7777_7777, 1'b0, 1'b1, 4'b0100, 1'b0, 32'h0};
        vecs[5] = '{"misshi", 32'hFFFF_0000, 1'b0, 32'h0,         4'h0, 4'h0, 0, 32'h0,         1'b0, 1'b0, 4'b0000, 1'b1, 32'h0};

        nReset = 1'b0; reqValid = 1'b0; reqAddr = '0; reqWrite = 1'b0;
        reqWData = '0; reqStrb = '0; reqProt = '0; rspReady = 1'b1;
        apbReady = 1'b0; apbRData = '0; apbSlvError = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_reqready", reqReady, 1'b0);
        chk("rst_rspvalid", rspValid, 1'b0);
        chk("rst_sel", apbSel, 4'h0);
        chk("rst_en", apbEnable, 1'b0);
        chk("rst_addr", apbAddr, 32'h0);
        chk("rst_rdata", rspRData, 32'h0);
        chk("rst_error", rspError, 1'b0);
        @(posedge clk); #1;
        nReset = 1'b1;
        @(negedge clk);
        chk("rst_release_reqready", reqReady, 1'b1);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Backpressure with slave error; a new command waits behind RESP
        @(posedge clk); #1;
        reqValid = 1'b1; reqAddr = 32'h0000_2008; reqWrite = 1'b0; reqProt = 4'h0;
        reqStrb = 4'hF; rspReady = 1'b0;
        @(posedge clk); #1;
        reqAddr = 32'h0000_0000; reqWrite = 1'b1; reqWData = 32'hFACE_0001; reqStrb = 4'h1;
        @(negedge clk);
        chk("bp_setup_sel", apbSel, 4'b0100);
        @(posedge clk); #1;
        apbReady = 1'b1; apbRData = 32'h55AA_33CC; apbSlvError = 1'b1;
        @(posedge clk); #1;
        apbReady = 1'b0; apbRData = 32'h0; apbSlvError = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_rspvalid", rspValid, 1'b1);
            chk("bp_error", rspError, 1'b1);
            chk("bp_rdata", rspRData, 32'h55AA_33CC);
            chk("bp_reqready", reqReady, 1'b0);
            chk("bp_sel", apbSel, 4'h0);
            @(posedge clk); #1;
        end
        rspReady = 1'b1;
        @(negedge clk);
        chk("bp_accept_rspvalid", rspValid, 1'b1);
        chk("bp_accept_reqready", reqReady, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_idle_reqready", reqReady, 1'b1);
        chk("bp_idle_rspvalid", rspValid, 1'b0);
        @(posedge clk); #1;
        reqValid = 1'b0;
        @(negedge clk);
        chk("bp_next_sel", apbSel, 4'b0001);
        chk("bp_next_addr", apbAddr, 32'h0);
        chk("bp_next_wdata", apbWData, 32'hFACE_0001);
        @(posedge clk); #1;
        apbReady = 1'b1; apbRData = 32'h9999_9999;
        @(posedge clk); #1;
        apbReady = 1'b0;
        @(negedge clk);
        chk("bp_next_rsp", rspValid, 1'b1);
        chk("bp_next_rdata", rspRData, 32'h0);
        chk("bp_next_error", rspError, 1'b0);

        // Reset during an ACCESS wait
        @(posedge clk); #1;
        reqValid = 1'b1; reqAddr = 32'h0000_2000; reqWrite = 1'b0;
        @(posedge clk); #1;
        reqValid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstacc_en", apbEnable, 1'b1);
        @(posedge clk); #1;
        nReset = 1'b0;
        @(negedge clk);
        chk("rstacc_low_reqready", reqReady, 1'b0);
        @(posedge clk); #1;
        nReset = 1'b1;
        @(negedge clk);
        chk("rstacc_sel", apbSel, 4'h0);
        chk("rstacc_en_off", apbEnable, 1'b0);
        chk("rstacc_reqready", reqReady, 1'b1);
        chk("rstacc_rspvalid", rspValid, 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rstacc_no_rsp", rspValid, 1'b0);
        end

        // Peripheral that never responds
        @(posedge clk); #1;
        reqValid = 1'b1; reqAddr = 32'h0000_1000; reqWrite = 1'b0; apbRData = 32'h6666_6666;
        @(posedge clk); #1;
        reqValid = 1'b0;
        @(negedge clk);
        chk("tmo_setup_sel", apbSel, 4'b0010);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!apbEnable) break;
            n++;
        end
`ifdef APB_TIMEOUT_EN
        chk("tmo_access_len", n, 16);
        chk("tmo_rspvalid", rspValid, 1'b1);
        chk("tmo_error", rspError, 1'b1);
        chk("tmo_rdata", rspRData, 32'h0);
        chk("tmo_sel", apbSel, 4'h0);
`else
        chk("notmo_access_len", n, 40);
        @(posedge clk); #1;
        apbReady = 1'b1; apbRData = 32'h0BAD_F00D;
        @(posedge clk); #1;
        apbReady = 1'b0;
        @(negedge clk);
        chk("notmo_rspvalid", rspValid, 1'b1);
        chk("notmo_rdata", rspRData, 32'h0BAD_F00D);
        chk("notmo_error", rspError, 1'b0);
`endif
        @(posedge clk); #1;
        @(negedge clk);
        chk("final_idle", reqReady, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_manager.md
APB_MANAGER -- requirements
Module: apb_manager

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): AddrWidth, 32, byte-address width; DataWidth, 32, data width (a multiple of 8); PrphNum, 4, number of peripherals and selector lanes; RegionBits, 12, log2 of the byte size of each peripheral region; TimeoutCycles, 16, ACCESS-cycle limit (used only with APB_TIMEOUT_EN).
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
  clk  in  1  clock
  nReset  in  1  reset; one clock; reset is synchronous and active-low
  reqValid  in  1  command valid
  reqReady  out  1  command accepted
  reqAddr  in  AddrWidth  byte address
  reqWrite  in  1  high = write, low = read
  reqWData  in  DataWidth  write data
  reqStrb  in  DataWidth/8  write strobe
  reqProt  in  4  protection attributes
  rspValid  out  1  response valid
  rspReady  in  1  response accepted
  rspRData  out  DataWidth  read data
  rspError  out  1  high = transfer error
  apbAddr  out  AddrWidth  APB address
  apbProt  out  4  APB protection
  apbSel  out  PrphNum  one-hot peripheral select
  apbEnable  out  1  ACCESS-phase enable
  apbWrite  out  1  APB direction
  apbWData  out  DataWidth  APB write data
  apbStrb  out  DataWidth/8  APB write strobe
  apbReady  in  1  peripheral ready
  apbRData  in  DataWidth  muxed read data
  apbSlvError  in  1  peripheral error

Function
REQ-003 The block SHALL implement the FSM states IDLE, SETUP, ACCESS and RESP.
REQ-004 reqReady SHALL be 1 only in IDLE, and a command SHALL be captured on the clock edge where reqValid and reqReady are both 1.
REQ-005 The decode index SHALL be reqAddr >> RegionBits; an index below PrphNum is a hit and sets the matching lane of apbSel, and any other index is a miss.
REQ-006 On a hit, the FSM SHALL go IDLE->SETUP, driving the addressed apbSel lane with apbEnable=0.
REQ-007 The FSM SHALL then go SETUP->ACCESS unconditionally, with apbEnable=1.
REQ-008 On a miss, the FSM SHALL go IDLE->RESP with rspError=1 and rspRData=0, and no APB select SHALL assert.
REQ-009 apbAddr, apbProt, apbWrite, apbWData and apbStrb SHALL be registered at capture and held stable from SETUP through the end of ACCESS.
REQ-010 apbStrb SHALL be forced to 0 for reads.
REQ-011 In ACCESS, the FSM SHALL stay while apbReady=0; on apbReady=1 it SHALL go to RESP and register the response as follows.
  - rspRData = apbRData for reads and 0 for writes.
  - rspError = apbSlvError.
REQ-012 apbSel and apbEnable SHALL be 0 in the cycle after apbReady is sampled high.
REQ-013 In RESP, rspValid SHALL be 1 and rspRData/rspError SHALL be held stable until rspReady=1; the FSM SHALL then return to IDLE.
REQ-014 With zero wait states, latency SHALL be: capture at edge 0, SETUP in cycle 1, ACCESS in cycle 2, rspValid in cycle 3.
REQ-015 Back-to-back commands SHALL be at most one per 4 cycles, and there SHALL be no pipelining.
REQ-016 In IDLE and RESP, apbSel and apbEnable SHALL be 0, and apbAddr/apbWrite/apbWData SHALL hold their last values.
REQ-017 reqValid in any state other than IDLE SHALL be ignored (not captured) until the FSM returns to IDLE.

Reset
REQ-018 nReset=0 sampled at a clk edge SHALL force IDLE.
REQ-019 On that reset, every output SHALL go to 0 except reqReady, which SHALL be 1 while nReset is high and the FSM is in IDLE.
REQ-020 Reset during SETUP, ACCESS or RESP SHALL abandon the transfer: apbSel=0 in the next cycle and no rspValid for the abandoned command.

Configuration
REQ-021 With APB_TIMEOUT_EN defined, a counter SHALL count ACCESS cycles.
REQ-022 If that count reaches TimeoutCycles with apbReady still 0, the FSM SHALL drop apbSel/apbEnable and enter RESP with rspError=1 and rspRData=0.
REQ-023 The timeout counter SHALL clear on each entry to SETUP.
REQ-024 If apbReady=1 arrives in the same cycle the count reaches TimeoutCycles, apbReady SHALL win.
REQ-025 Without APB_TIMEOUT_EN, ACCESS SHALL wait indefinitely, there SHALL be no counter logic, and TimeoutCycles SHALL be unused.

Structure
REQ-026 Package apb_pkg SHALL hold the FSM state enum typedef, the 4-bit prot field typedef, and the default width constants.
REQ-027 Sub-module apb_decoder (combinational; address in, one-hot sel and hit out) SHALL perform address decode.
REQ-028 apb_manager SHALL contain the FSM, the capture registers, the response registers and the timeout counter.

Verification
REQ-029 The bench SHALL cover a zero-wait write: addr 0x1004, wData 0xDEADBEEF, strb 0xF, apbReady tied 1 -> apbSel=4'b0010 in cycles 1-2, apbEnable only in cycle 2, rspValid in cycle 3 with rspError=0 and rspRData=0.
REQ-030 The bench SHALL cover a read with 3 wait states: addr 0x3000, apbRData 0x12345678 on the ready cycle -> ACCESS lasts 4 cycles, apbStrb=0, rspRData=0x12345678, and address stable throughout.
REQ-031 The bench SHALL cover a decode miss: addr 0x4000 with PrphNum=4 -> no apbSel, rspValid=1 with rspError=1 in the cycle after capture.
REQ-032 The bench SHALL cover response backpressure and slave error: apbSlvError=1, rspReady held 0 for 5 cycles -> rspValid and data stable for 5 cycles, reqReady=0 until the cycle after rspReady=1.
REQ-033 The bench SHALL cover reset in ACCESS: nReset=0 for 1 cycle mid-wait -> next cycle apbSel=0, apbEnable=0, reqReady=1, and no rspValid.
REQ-034 With APB_TIMEOUT_EN, TimeoutCycles=16 and apbReady never asserted, the bench SHALL see ACCESS last 16 cycles, then rspError=1 with rspRData=0.
